// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scanner: segment patterns,
// digit-slot encodings and small helpers used by the decoder and the scanner.
package seg7_pkg;

    localparam int BCD_W      = 4;
    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 4;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDX_ONES      = 2'd0,
        IDX_TENS      = 2'd1,
        IDX_HUNDREDS  = 2'd2,
        IDX_THOUSANDS = 2'd3
    } digit_idx_e;

    function automatic digit_idx_e next_idx(input digit_idx_e idx);
        case (idx)
            IDX_ONES:      next_idx = IDX_TENS;
            IDX_TENS:      next_idx = IDX_HUNDREDS;
            IDX_HUNDREDS:  next_idx = IDX_THOUSANDS;
            default:       next_idx = IDX_ONES;
        endcase
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_for_idx(input digit_idx_e idx);
        case (idx)
            IDX_ONES:      an_for_idx = 4'b1110;
            IDX_TENS:      an_for_idx = 4'b1101;
            IDX_HUNDREDS:  an_for_idx = 4'b1011;
            default:       an_for_idx = 4'b0111;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes go dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: holds a loaded BCD value and
// scans one digit per REFRESH_DIV cycles with optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000  // cycles per digit slot, minimum 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BCD_W-1:0]      ones,
    input  logic [BCD_W-1:0]      tens,
    input  logic [BCD_W-1:0]      hundreds,
    input  logic [BCD_W-1:0]      thousands,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick;
    digit_idx_e            idx_q, idx_d;

    logic [BCD_W-1:0]      ones_q, ones_d;
    logic [BCD_W-1:0]      tens_q, tens_d;
    logic [BCD_W-1:0]      hund_q, hund_d;
    logic [BCD_W-1:0]      thou_q, thou_d;

    logic                  blank_thou, blank_hund, blank_tens;
    logic                  blank_sel;
    logic [BCD_W-1:0]      digit_sel;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? next_idx(idx_q) : idx_q;

        ones_d = load ? ones      : ones_q;
        tens_d = load ? tens      : tens_q;
        hund_d = load ? hundreds  : hund_q;
        thou_d = load ? thousands : thou_q;
    end

    // The output register is fed from next-state values so a load or tick
    // taking effect at an edge is visible on seg/an from that same edge.
    always_comb begin
        blank_thou = blank_lz && (thou_d == '0);
        blank_hund = blank_thou && (hund_d == '0);
        blank_tens = blank_hund && (tens_d == '0);

        digit_sel = ones_d;
        blank_sel = 1'b0;
        case (idx_d)
            IDX_ONES: begin
                digit_sel = ones_d;
                blank_sel = 1'b0;
            end
            IDX_TENS: begin
                digit_sel = tens_d;
                blank_sel = blank_tens;
            end
            IDX_HUNDREDS: begin
                digit_sel = hund_d;
                blank_sel = blank_hund;
            end
            default: begin
                digit_sel = thou_d;
                blank_sel = blank_thou;
            end
        endcase
    end

    seg7_decode u_decode (
        .bcd_i (digit_sel),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = blank_sel ? SEG_BLANK : dec_seg;
        an_d  = blank_sel ? AN_OFF    : an_for_idx(idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= IDX_ONES;
            ones_q <= '0;
            tens_q <= '0;
            hund_q <= '0;
            thou_q <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            hund_q <= hund_d;
            thou_q <= thou_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a 4-cycle digit slot.
module tb_seg7_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] thousands = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int tests = 0;
    int fails = 0;
    int n = 0;  // rising edges since the last reset release

    always #5 clk = ~clk;

    seg7_scan #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic load_digits(input logic [3:0] th, input logic [3:0] hu,
                               input logic [3:0] te, input logic [3:0] on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    function automatic logic [3:0] an_exp(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
        tests++;
        if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", an); end
        tests++;
        if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", dp); end
        @(posedge clk);
        #1;
        tests++;
        if (seg !== 7'h7F || an !== 4'b1111) begin
            fails++; $display("FAIL reset_hold got seg=%h an=%b want seg=7f an=1111", seg, an);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 20; k++) begin
            step();
            tests++;
            if (an !== an_exp((n / DIV) % 4) || seg !== 7'h40) begin
                fails++;
                $display("FAIL idle_scan edge=%0d got an=%b seg=%h want an=%b seg=40",
                         n, an, seg, an_exp((n / DIV) % 4));
            end
        end
    endtask

    task automatic test_digits();
        logic [6:0] es;
        int idx;
        load_digits(4'd1, 4'd0, 4'd2, 4'd3);
        for (int k = 0; k < 17; k++) begin
            if (k != 0) step();
            idx = (n / DIV) % 4;
            case (idx)
                0: es = 7'h30;
                1: es = 7'h24;
                2: es = 7'h40;
                default: es = 7'h79;
            endcase
            tests++;
            if (an !== an_exp(idx) || seg !== es) begin
                fails++;
                $display("FAIL digits_1023 slot=%0d got an=%b seg=%h want an=%b seg=%h",
                         idx, an, seg, an_exp(idx), es);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] es;
        logic [3:0] ea;
        int idx;
        blank_lz = 1'b1;
        load_digits(4'd0, 4'd0, 4'd4, 4'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            idx = (n / DIV) % 4;
            case (idx)
                0: begin es = 7'h40; ea = 4'b1110; end
                1: begin es = 7'h19; ea = 4'b1101; end
                default: begin es = 7'h7F; ea = 4'b1111; end
            endcase
            tests++;
            if (an !== ea || seg !== es) begin
                fails++;
                $display("FAIL blank_0040 slot=%0d got an=%b seg=%h want an=%b seg=%h",
                         idx, an, seg, ea, es);
            end
        end
        load_digits(4'd0, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            idx = (n / DIV) % 4;
            if (idx == 0) begin es = 7'h40; ea = 4'b1110; end
            else begin es = 7'h7F; ea = 4'b1111; end
            tests++;
            if (an !== ea || seg !== es) begin
                fails++;
                $display("FAIL blank_0000 slot=%0d got an=%b seg=%h want an=%b seg=%h",
                         idx, an, seg, ea, es);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_load_tick();
        int guard;
        guard = 0;
        while ((n % 16) != 15 && guard < 32) begin
            step();
            guard++;
        end
        tests++;
        if (guard >= 32) begin fails++; $display("FAIL load_tick_align budget expired at edge %0d", n); end
        load_digits(4'd0, 4'd0, 4'd0, 4'd7);
        tests++;
        if (an !== 4'b1110 || seg !== 7'h78) begin
            fails++;
            $display("FAIL load_tick got an=%b seg=%h want an=1110 seg=78", an, seg);
        end
    endtask

    task automatic test_invalid();
        int guard;
        load_digits(4'd0, 4'd0, 4'd0, 4'd12);
        guard = 0;
        while (((n / DIV) % 4) != 0 && guard < 32) begin
            step();
            guard++;
        end
        tests++;
        if (guard >= 32) begin fails++; $display("FAIL invalid_align budget expired at edge %0d", n); end
        tests++;
        if (an !== 4'b1110 || seg !== 7'h7F) begin
            fails++;
            $display("FAIL invalid_code got an=%b seg=%h want an=1110 seg=7f", an, seg);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while ((n % DIV) != 2 && guard < 16) begin
            step();
            guard++;
        end
        tests++;
        if (guard >= 16) begin fails++; $display("FAIL rst_mid_align budget expired at edge %0d", n); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (seg !== 7'h7F || an !== 4'b1111) begin
            fails++; $display("FAIL rst_mid_immediate got seg=%h an=%b want seg=7f an=1111", seg, an);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++;
            if (an !== ((k < 4) ? 4'b1110 : 4'b1101) || seg !== 7'h40) begin
                fails++;
                $display("FAIL rst_mid_release edge=%0d got an=%b seg=%h want an=%b seg=40",
                         k, an, seg, (k < 4) ? 4'b1110 : 4'b1101);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_digits();
        test_blanking();
        test_load_tick();
        test_invalid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL expose parameter REFRESH_DIV, default 100000, giving the clock cycles per digit slot; the legal minimum is 2.
REQ-002 The block SHALL expose port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL expose port load, input, 1 bit: a one-cycle strobe that captures the four digit inputs.
REQ-005 The block SHALL expose ports ones, tens, hundreds and thousands, each input, 4 bits: BCD digits from the upstream binary-to-BCD stage.
REQ-006 The block SHALL expose port blank_lz, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-007 The block SHALL expose port seg, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-008 The block SHALL expose port dp, output, 1 bit: active-low decimal point, held inactive (1).
REQ-009 The block SHALL expose port an, output, 4 bits: active-low digit enables; an[0] is ones and an[3] is thousands.

Function
REQ-010 When load=1 at a rising edge, the block SHALL capture all four digits into holding registers; when load=0, the holding registers SHALL keep their values.
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; a tick SHALL occur in the cycle the count equals REFRESH_DIV-1.
REQ-012 On each tick, the scan index SHALL advance 0->1->2->3->0 (ones, tens, hundreds, thousands, then wrap).
REQ-013 seg and an SHALL be registered and SHALL reflect the current scan index and holding registers with one cycle of latency.
REQ-014 For the selected digit, an SHALL drive the enable for the current index low and the other three enables high.
REQ-015 Decode SHALL be 0:0x40, 1:0x79, 2:0x24, 3:0x30, 4:0x19, 5:0x12, 6:0x02, 7:0x78, 8:0x00, 9:0x10; codes 10-15 SHALL give 0x7F.
REQ-016 With blank_lz=1, the block SHALL blank thousands if it is 0, hundreds if thousands and hundreds are both 0, and tens if thousands, hundreds and tens are all 0; ones SHALL never be blanked.
REQ-017 A blanked digit SHALL drive seg=0x7F and an=4'b1111 for its whole slot.
REQ-018 Blanking SHALL be evaluated on the holding registers, never on the live inputs.
REQ-019 If load and tick coincide, the block SHALL apply both updates, and the newly indexed digit SHALL show the newly loaded value.
REQ-020 The block SHALL have no handshake back-pressure; a load during a slot SHALL update seg within one cycle and SHALL NOT restart the prescaler.

Reset
REQ-021 Asserting rst SHALL immediately clear the prescaler, scan index and holding registers, and SHALL set seg=0x7F, an=4'b1111 and dp=1.
REQ-022 In the first rising edge after rst deasserts, the block SHALL drive an=4'b1110 and seg=0x40.
REQ-023 Reset asserted mid-slot SHALL discard the partial count; no tick SHALL occur until REFRESH_DIV cycles after release.

Structure
REQ-024 A shared package seg7_pkg SHALL hold the ten segment constants, SEG_BLANK=0x7F and the digit-index encodings.
REQ-025 A combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low seg out) SHALL be instantiated once on the muxed digit.
REQ-026 The prescaler width SHALL be derived from REFRESH_DIV; there SHALL be no hard-coded widths.

Verification
REQ-027 The bench SHALL use REFRESH_DIV=4; reset, then 20 idle cycles -> an cycles 1110,1101,1011,0111 every 4 cycles and seg=0x40 throughout (blank_lz=0).
REQ-028 load digits 1,0,2,3 (thousands..ones) with blank_lz=0 -> slots show seg 0x30, 0x24, 0x40, 0x79 on ones, tens, hundreds, thousands.
REQ-029 blank_lz=1, load 0,0,4,0 (thousands..ones) -> ones 0x40, tens 0x19, hundreds and thousands an=1111/seg=0x7F; load 0,0,0,0 -> only ones lit with 0x40.
REQ-030 Load pulse in the same cycle as the 3->0 tick with ones=7 -> the next cycle shows an=1110 and seg=0x78.
REQ-031 Load ones=12 (invalid code) -> ones slot seg=0x7F with an[0]=0 when blank_lz=0.
REQ-032 rst pulsed mid-slot at prescaler=2 -> outputs go to their reset values immediately; the first post-reset tick arrives exactly 4 cycles after release.
